// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: state encodings, the all-zero
// pattern substitute and small pattern helpers used by the top-level FSM.
package led_seq_pkg;

    localparam int PAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } seq_state_t;

    // An all-dark pattern would rotate forever without showing anything.
    localparam logic [PAT_W-1:0] ZERO_PAT_SUB = 8'h01;

    function automatic logic [PAT_W-1:0] loadPattern(input logic [PAT_W-1:0] swVal);
        return (swVal == '0) ? ZERO_PAT_SUB : swVal;
    endfunction

    function automatic logic [PAT_W-1:0] rotatePattern(input logic [PAT_W-1:0] pat,
                                                      input logic              dir);
        return dir ? {pat[0], pat[PAT_W-1:1]} : {pat[PAT_W-2:0], pat[PAT_W-1]};
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Synchronises and debounces one active-low pushbutton and emits a single
// pulse when the settled level falls.
module pb_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_n,
    output logic level,
    output logic press
);

    localparam int              DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_armed;
    logic [DEB_W-1:0] r_cnt;
    logic [DEB_W-1:0] r_relCnt;

    // Presses stay disarmed after reset until a full run of released samples
    // is seen, so a button held through reset cannot fire on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_level  <= 1'b1;
            r_press  <= 1'b0;
            r_armed  <= 1'b0;
            r_cnt    <= '0;
            r_relCnt <= '0;
        end else begin
            r_sync1 <= pb_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;

            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_armed & ~r_sync2;
            end else begin
                r_cnt <= r_cnt + DEB_W'(1);
            end

            if (!r_armed) begin
                if (!r_sync2) begin
                    r_relCnt <= '0;
                end else if (r_relCnt == DEB_LAST) begin
                    r_relCnt <= '0;
                    r_armed  <= 1'b1;
                end else begin
                    r_relCnt <= r_relCnt + DEB_W'(1);
                end
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: mirrors the switches in IDLE, rotates a loaded
// pattern in RUN and shows its complement while PAUSEd.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int DEB_CYCLES  = 250000,
    parameter int STEP_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       pba,
    input  logic       pbb,
    output logic [7:0] led,
    output logic [1:0] mode
);

    localparam int                STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic              w_levelA;
    logic              w_levelB;
    logic              w_pulseA;
    logic              w_pulseB;
    logic              w_pressA;
    logic              w_pressB;
    logic              w_stepTerm;

    seq_state_t        r_state;
    logic [PAT_W-1:0]  r_pat;
    logic              r_dir;
    logic [STEP_W-1:0] r_stepCnt;
    logic [PAT_W-1:0]  r_led;

    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debA (
        .clk   (clk),
        .rst   (rst),
        .pb_n  (pba),
        .level (w_levelA),
        .press (w_pulseA)
    );

    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debB (
        .clk   (clk),
        .rst   (rst),
        .pb_n  (pbb),
        .level (w_levelB),
        .press (w_pulseB)
    );

    // A pulse always coincides with the settled level reading pressed.
    assign w_pressA   = w_pulseA & ~w_levelA;
    assign w_pressB   = w_pulseB & ~w_levelB;
    assign w_stepTerm = (r_stepCnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pat     <= '0;
            r_dir     <= 1'b0;
            r_stepCnt <= '0;
            r_led     <= '0;
        end else begin
            case (r_state)
                ST_RUN:   r_led <= r_pat;
                ST_PAUSE: r_led <= ~r_pat;
                default:  r_led <= sw;
            endcase

            if (w_pressA && w_pressB) begin
                r_state   <= ST_IDLE;
                r_pat     <= '0;
                r_stepCnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pressA) begin
                            r_pat     <= loadPattern(sw);
                            r_stepCnt <= '0;
                            r_state   <= ST_RUN;
                        end else if (w_pressB) begin
                            r_dir <= ~r_dir;
                        end
                    end
                    ST_RUN: begin
                        if (w_pressA) begin
                            r_pat     <= loadPattern(sw);
                            r_stepCnt <= '0;
                        end else begin
                            // A pause request still lets a due rotate land.
                            if (w_stepTerm) begin
                                r_pat     <= rotatePattern(r_pat, r_dir);
                                r_stepCnt <= '0;
                            end else if (!w_pressB) begin
                                r_stepCnt <= r_stepCnt + STEP_W'(1);
                            end
                            if (w_pressB) begin
                                r_state <= ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (w_pressA) begin
                            r_pat     <= loadPattern(sw);
                            r_stepCnt <= '0;
                            r_state   <= ST_RUN;
                        end else if (w_pressB) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign led  = r_led;
    assign mode = r_state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with short debounce and step periods;
// every expected value below is hand-derived from the cycle timing.
module tb_led_seq_ctrl;

    localparam int DEB  = 4;
    localparam int STEP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'h00;
    logic       pba = 1'b1;
    logic       pbb = 1'b1;
    logic [7:0] led;
    logic [1:0] mode;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .DEB_CYCLES  (DEB),
        .STEP_CYCLES (STEP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .pba  (pba),
        .pbb  (pbb),
        .led  (led),
        .mode (mode)
    );

    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 8'h%02h, want 8'h%02h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] swVal, input logic pbaVal,
                                 input logic pbbVal);
        sw  = swVal;
        pba = pbaVal;
        pbb = pbbVal;
    endtask

    // A press driven at a falling edge is acted on by the FSM 7 edges later;
    // the task returns just after that edge with the buttons released.
    task automatic pressButtons(input logic a, input logic b);
        pba = ~a;
        pbb = ~b;
        waitCycles(7);
        pba = 1'b1;
        pbb = 1'b1;
    endtask

    initial begin
        applyStimulus(8'h00, 1'b1, 1'b1);
        rst = 1'b1;
        waitCycles(3);
        checkOutput("rstLed", led, 8'h00);
        checkOutput("rstMode", {6'b0, mode}, 8'h00);
        rst = 1'b0;

        applyStimulus(8'hA5, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("idleLedA5", led, 8'hA5);
        checkOutput("idleMode", {6'b0, mode}, 8'h00);
        waitCycles(8);

        // Bounce: never four identical low samples in a row.
        for (int i = 0; i < 5; i++) begin
            pba = 1'b0;
            waitCycles(2);
            pba = 1'b1;
            waitCycles(2);
        end
        waitCycles(10);
        checkOutput("bounceMode", {6'b0, mode}, 8'h00);
        checkOutput("bounceLed", led, 8'hA5);

        // Press A with sw=81, held 10 cycles.
        applyStimulus(8'h81, 1'b0, 1'b1);
        waitCycles(6);
        checkOutput("prePressMode", {6'b0, mode}, 8'h00);
        waitCycles(1);
        checkOutput("runMode", {6'b0, mode}, 8'h01);
        waitCycles(1);
        checkOutput("runLoad", led, 8'h81);
        waitCycles(2);
        pba = 1'b1;
        waitCycles(5);
        checkOutput("runHold", led, 8'h81);
        waitCycles(1);
        checkOutput("rotate1", led, 8'h03);
        waitCycles(8);
        checkOutput("rotate2", led, 8'h06);

        // Reload lands on a terminal count: the reload must win.
        applyStimulus(8'h03, 1'b0, 1'b1);
        waitCycles(7);
        checkOutput("reloadMode", {6'b0, mode}, 8'h01);
        pbb = 1'b0;
        waitCycles(1);
        checkOutput("reloadWins", led, 8'h03);
        waitCycles(2);
        pba = 1'b1;
        waitCycles(4);
        checkOutput("pauseMode", {6'b0, mode}, 8'h02);
        waitCycles(1);
        checkOutput("pauseLed", led, 8'hFC);
        waitCycles(2);
        pbb = 1'b1;
        waitCycles(40);
        checkOutput("pauseHoldMode", {6'b0, mode}, 8'h02);
        checkOutput("pauseHoldLed", led, 8'hFC);

        // Resume: counter was held at 6, so the rotate comes two edges later.
        pressButtons(1'b0, 1'b1);
        checkOutput("resumeMode", {6'b0, mode}, 8'h01);
        waitCycles(1);
        checkOutput("resumeLed", led, 8'h03);
        waitCycles(1);
        checkOutput("resumeHeld", led, 8'h03);
        waitCycles(1);
        checkOutput("resumeRotate", led, 8'h06);

        // Pause request on a terminal count: rotate 0C->18 still happens.
        waitCycles(8);
        pressButtons(1'b0, 1'b1);
        checkOutput("rotPauseMode", {6'b0, mode}, 8'h02);
        waitCycles(1);
        checkOutput("rotPauseLed", led, 8'hE7);

        // Back to RUN, then coincident A and B presses.
        waitCycles(6);
        pressButtons(1'b0, 1'b1);
        checkOutput("resume2Mode", {6'b0, mode}, 8'h01);
        waitCycles(7);
        sw = 8'h5A;
        pressButtons(1'b1, 1'b1);
        checkOutput("bothMode", {6'b0, mode}, 8'h00);
        waitCycles(1);
        checkOutput("bothLed", led, 8'h5A);

        // B in IDLE flips to right rotation; zero switches load 01.
        waitCycles(7);
        pressButtons(1'b0, 1'b1);
        checkOutput("idleBMode", {6'b0, mode}, 8'h00);
        waitCycles(7);
        sw = 8'h00;
        pressButtons(1'b1, 1'b0);
        checkOutput("zeroLoadMode", {6'b0, mode}, 8'h01);
        waitCycles(1);
        checkOutput("zeroLoadLed", led, 8'h01);
        waitCycles(7);
        checkOutput("zeroHoldLed", led, 8'h01);
        waitCycles(1);
        checkOutput("rotateRight", led, 8'h80);

        // Reset in the middle of a press, button still held afterwards.
        pba = 1'b0;
        waitCycles(3);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(12);
        checkOutput("heldRstMode", {6'b0, mode}, 8'h00);
        checkOutput("heldRstLed", led, 8'h00);
        pba = 1'b1;
        waitCycles(10);
        sw = 8'h3C;
        pressButtons(1'b1, 1'b0);
        checkOutput("rePressMode", {6'b0, mode}, 8'h01);
        waitCycles(1);
        checkOutput("rePressLed", led, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 250000: consecutive stable samples required to accept a new pushbutton level.
REQ-002 SHALL have parameter STEP_CYCLES, default 12500000: clock cycles between pattern steps in RUN.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port `clk`: input, 1 bit, system clock; all state changes on its rising edge.
REQ-005 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-006 Port `sw`: input, 8 bits, slide switches (static, not synchronised).
REQ-007 Port `pba`: input, 1 bit, pushbutton A, asynchronous, active-low (0 = pressed).
REQ-008 Port `pbb`: input, 1 bit, pushbutton B, asynchronous, active-low (0 = pressed).
REQ-009 Port `led`: output, 8 bits, registered LED drive.
REQ-010 Port `mode`: output, 2 bits, current state (IDLE=0, RUN=1, PAUSE=2).

Function
REQ-011 Each button SHALL pass through a 2-FF synchroniser, then a debouncer that adopts the new level only after DEB_CYCLES consecutive identical synchronised samples.
REQ-012 A press event SHALL be a one-cycle pulse on the debounced level going 1->0; release SHALL generate no event.
REQ-013 FSM states: IDLE, RUN, PAUSE; 2'b11 unreachable and SHALL recover to IDLE next cycle.
REQ-014 IDLE: the next led value SHALL be sw, so led = sw delayed by 1 cycle.
REQ-015 IDLE + A press: pat <= sw (sw == 0 loads 8'h01), step counter <= 0, state <= RUN.
REQ-016 IDLE + B press: dir toggles (0 = rotate left, 1 = rotate right); state unchanged.
REQ-017 RUN: step counter counts 0..STEP_CYCLES-1; on the terminal count, pat rotates one bit per dir, and the counter wraps to 0.
REQ-018 RUN + B press: state <= PAUSE; pat held; step counter held.
REQ-019 PAUSE + B press: state <= RUN; step counter resumes from its held value.
REQ-020 RUN or PAUSE + A press: reload pat from sw (sw == 0 -> 8'h01), clear counter, state <= RUN.
REQ-021 In RUN and PAUSE, the next led value SHALL be pat in RUN and ~pat in PAUSE.
REQ-022 A and B press pulses in the same cycle, any state: state <= IDLE, pat <= 0, counter <= 0; dir unchanged.
REQ-023 Press pulse at cycle N: state/pat SHALL update at edge N+1; led SHALL reflect it at edge N+2.
REQ-024 A rotate on the terminal count and an A press in the same cycle: the reload wins; no rotate.
REQ-025 A rotate on the terminal count and a B press (RUN -> PAUSE) in the same cycle: the rotate SHALL occur; PAUSE then shows ~rotated pat.
REQ-026 Step counter width SHALL be $clog2(STEP_CYCLES), minimum 1; debounce counter width SHALL be $clog2(DEB_CYCLES+1).

Reset
REQ-027 On rst = 1 at a clock edge: state IDLE, pat 8'h00, dir 0, step and debounce counters 0, led 8'h00, mode 2'b00.
REQ-028 On reset, synchroniser and debounced levels SHALL be 1 (released), so no press event is generated when rst deasserts.
REQ-029 Reset mid-RUN or mid-debounce SHALL abandon all progress; a button held through reset SHALL produce no event until it is released and pressed again.

Structure
REQ-030 State encodings (IDLE/RUN/PAUSE) and the zero-pattern substitute 8'h01 SHALL live in shared package led_seq_pkg.
REQ-031 Debounce logic SHALL be a sub-module pb_debounce (params DEB_CYCLES; ports clk, rst, pb_n, level, press), instantiated once per button.
REQ-032 The top level SHALL contain only the FSM, pattern/dir registers, step counter and led register.

Verification (bench overrides DEB_CYCLES=4, STEP_CYCLES=8)
REQ-033 Reset, then sw=8'hA5 in IDLE -> led=8'hA5 one cycle later; mode=0.
REQ-034 sw=8'h81; pba low for 10 cycles -> exactly one press; mode=1; led=8'h81; after 8 cycles led=8'h03, after 16 cycles 8'h06.
REQ-035 pba toggled every 2 cycles for 20 cycles (bounce), then released -> no press event; mode stays 0.
REQ-036 In RUN with pat=8'h03, press pbb -> mode=2, led=8'hFC, holds 40 cycles; press pbb again -> mode=1 and the next rotate after the remaining count.
REQ-037 In IDLE, press pbb (dir=1); sw=8'h00, press pba -> pat=8'h01; after 8 cycles led=8'h80.
REQ-038 In RUN, drive pba and pbb low together so press pulses coincide -> mode=0, led follows sw; assert rst mid-press -> no event after deassert until re-press.
